// File: rtl/ddr_pkg.sv
// ddr_pkg: shared DDR timing defaults and refresh scheduler enums.
package ddr_pkg;
    localparam int DEF_T_RC         = 45;
    localparam int DEF_T_MOD        = 24;
    localparam int DEF_T_REFI       = 6240;
    localparam int DEF_T_REF_ALMOST = 64;
    localparam int DEF_T_RP         = 16;
    localparam int DEF_T_RFC        = 280;
    localparam int DEF_MAX_POSTPONE = 8;

    typedef enum logic [2:0] {ST_IDLE, ST_PREA, ST_TRP, ST_REF, ST_TRFC, ST_DONE} ref_state_t;
    typedef enum logic [1:0] {REF_NOP = 2'd0, REF_PREA = 2'd1, REF_REF = 2'd2} ref_cmd_t;
endpackage

// File: rtl/ddr_refresh_sched_if.sv
// ddr_refresh_sched_if: controller <-> refresh scheduler signals.
interface ddr_refresh_sched_if;
    import ddr_pkg::*;
    logic       ini_done;
    logic       ref_go;
    logic       clear_refresh;
    logic       refresh_almost;
    logic       refresh_done;
    logic       ref_cmd_valid;
    ref_cmd_t   ref_cmd;
    logic [3:0] ref_pending;
    logic       ref_overflow;

    modport master (output ini_done, ref_go, clear_refresh,
                    input refresh_almost, refresh_done, ref_cmd_valid, ref_cmd, ref_pending, ref_overflow);
    modport slave  (input ini_done, ref_go, clear_refresh,
                    output refresh_almost, refresh_done, ref_cmd_valid, ref_cmd, ref_pending, ref_overflow);
endinterface

// File: rtl/ref_interval_cnt.sv
// ref_interval_cnt: tREFI interval counter with postponed-refresh and early-refresh credit tracking.
module ref_interval_cnt #(
    parameter int T_REFI       = 6240,
    parameter int T_ALMOST     = 64,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ini_done,
    input  logic       ref_issue,
    output logic       almost,
    output logic [3:0] pending,
    output logic       overflow
);
    localparam int CW = $clog2(T_REFI);

    logic [CW-1:0] count;
    logic          credit;
    logic          tick;

    assign tick   = ini_done && count == CW'(T_REFI - 1);
    assign almost = pending != 4'd0 || (count >= CW'(T_REFI - T_ALMOST) && !credit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            pending  <= '0;
            credit   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count <= (!ini_done || tick) ? '0 : count + CW'(1);
            // a tick and a REF together cancel out: pending unchanged, no credit kept
            if (tick && ref_issue)
                credit <= 1'b0;
            else if (tick) begin
                if (credit)
                    credit <= 1'b0;
                else if (pending == 4'(MAX_POSTPONE))
                    overflow <= 1'b1;
                else
                    pending <= pending + 4'd1;
            end else if (ref_issue) begin
                if (pending != 4'd0)
                    pending <= pending - 4'd1;
                else
                    credit <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/ddr_refresh_sched.sv
// ddr_refresh_sched: refresh scheduler sequencing PREA -> tRP -> REF -> tRFC on controller grant.
module ddr_refresh_sched
    import ddr_pkg::*;
#(
    parameter int T_REFI       = DEF_T_REFI,
    parameter int T_ALMOST     = DEF_T_REF_ALMOST,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_RFC        = DEF_T_RFC,
    parameter int MAX_POSTPONE = DEF_MAX_POSTPONE
) (
    input logic                 CK_t,
    input logic                 reset_n,
    ddr_refresh_sched_if.slave  bus
);
    localparam int T_MAX = T_RP > T_RFC ? T_RP : T_RFC;
    localparam int TW    = $clog2(T_MAX);

    ref_state_t    state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          almost_raw;

    ref_interval_cnt #(
        .T_REFI(T_REFI), .T_ALMOST(T_ALMOST), .MAX_POSTPONE(MAX_POSTPONE)
    ) u_cnt (
        .clk(CK_t),
        .rst_n(reset_n),
        .ini_done(bus.ini_done),
        .ref_issue(state == ST_REF),
        .almost(almost_raw),
        .pending(bus.ref_pending),
        .overflow(bus.ref_overflow)
    );

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

    // timers load N-2 so REF/DONE land exactly N cycles after PREA/REF
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        case (state)
            ST_IDLE: if (bus.ref_go && !bus.clear_refresh && almost_raw) state_nx = ST_PREA;
            ST_PREA: begin
                state_nx = ST_TRP;
                timer_nx = TW'(T_RP - 2);
            end
            ST_TRP:  if (timer == '0) state_nx = ST_REF; else timer_nx = timer - TW'(1);
            ST_REF: begin
                state_nx = ST_TRFC;
                timer_nx = TW'(T_RFC - 2);
            end
            ST_TRFC: if (timer == '0) state_nx = ST_DONE; else timer_nx = timer - TW'(1);
            ST_DONE: if (bus.clear_refresh) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        bus.refresh_almost = almost_raw && state == ST_IDLE;
        bus.refresh_done   = state == ST_DONE;
        bus.ref_cmd_valid  = state == ST_PREA || state == ST_REF;
        bus.ref_cmd        = state == ST_PREA ? REF_PREA : state == ST_REF ? REF_REF : REF_NOP;
    end
endmodule

// File: tb/tb_ddr_refresh_sched.sv
// tb_ddr_refresh_sched: scenario tasks plus a command scoreboard for the refresh scheduler.
module tb_ddr_refresh_sched;
    import ddr_pkg::*;

    localparam int T_REFI = 100, T_ALMOST = 10, T_RP = 3, T_RFC = 8;

    typedef struct {
        ref_cmd_t cmd;
        int       cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   mcnt = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    ddr_refresh_sched_if bus();

    ddr_refresh_sched #(
        .T_REFI(T_REFI), .T_ALMOST(T_ALMOST), .T_RP(T_RP), .T_RFC(T_RFC), .MAX_POSTPONE(8)
    ) dut (
        .CK_t(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) mcnt <= 0;
        else mcnt <= !bus.ini_done ? 0 : (mcnt == T_REFI - 1 ? 0 : mcnt + 1);

    always @(negedge clk) begin
        if (reset_n && bus.ref_cmd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: got cmd %0d at cycle %0d, required none", bus.ref_cmd, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.ref_cmd !== e.cmd || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL cmd_order: got cmd %0d at cycle %0d, required cmd %0d at cycle %0d",
                             bus.ref_cmd, cyc, e.cmd, e.cyc);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_count(input int target);
        for (int i = 0; i < 2 * T_REFI && mcnt != target; i++) @(negedge clk);
    endtask

    // grants one refresh, records expected PREA/REF, returns grant and done cycles, then clears
    task automatic do_grant(output int c0, output int dcyc);
        c0 = cyc;
        bus.clear_refresh = 1'b0;
        bus.ref_go = 1'b1;
        exp_q.push_back('{REF_PREA, c0 + 1});
        exp_q.push_back('{REF_REF, c0 + 1 + T_RP});
        dcyc = -1;
        for (int i = 0; i < 40 && dcyc < 0; i++) begin
            @(negedge clk);
            if (bus.refresh_done) dcyc = cyc;
        end
        bus.ref_go = 1'b0;
        bus.clear_refresh = 1'b1;
        @(negedge clk);
        bus.clear_refresh = 1'b0;
    endtask

    task automatic test_reset;
        bus.ini_done = 1'b0;
        bus.ref_go = 1'b0;
        bus.clear_refresh = 1'b0;
        step(3);
        checks++;
        if ({bus.refresh_almost, bus.refresh_done, bus.ref_cmd_valid, bus.ref_cmd, bus.ref_pending, bus.ref_overflow} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {bus.refresh_almost, bus.refresh_done, bus.ref_cmd_valid, bus.ref_cmd, bus.ref_pending, bus.ref_overflow});
        end
        reset_n = 1'b1;
        bus.ini_done = 1'b1;
    endtask

    task automatic test_idle;
        step(T_REFI - T_ALMOST - 1);
        checks++;
        if (bus.refresh_almost !== 1'b0) begin
            errors++;
            $display("FAIL almost_early: got %b at count %0d, required 0", bus.refresh_almost, mcnt);
        end
        step(1);
        checks++;
        if (bus.refresh_almost !== 1'b1) begin
            errors++;
            $display("FAIL almost_rise: got %b at count %0d, required 1", bus.refresh_almost, mcnt);
        end
        step(T_ALMOST - 1);
        checks++;
        if (bus.ref_pending !== 4'd0) begin
            errors++;
            $display("FAIL pending_pre_tick: got %0d, required 0", bus.ref_pending);
        end
        step(1);
        checks++;
        if (bus.ref_pending !== 4'd1) begin
            errors++;
            $display("FAIL pending_tick: got %0d, required 1", bus.ref_pending);
        end
    endtask

    task automatic test_service;
        int c0, dcyc;
        do_grant(c0, dcyc);
        checks++;
        if (dcyc !== c0 + 1 + T_RP + T_RFC) begin
            errors++;
            $display("FAIL service_done_cycle: got %0d, required %0d", dcyc, c0 + 1 + T_RP + T_RFC);
        end
        checks++;
        if (bus.ref_pending !== 4'd0 || bus.refresh_done !== 1'b0 || bus.refresh_almost !== 1'b0) begin
            errors++;
            $display("FAIL service_after_clear: got pending %0d done %b almost %b, required 0 0 0",
                     bus.ref_pending, bus.refresh_done, bus.refresh_almost);
        end
    endtask

    task automatic test_early;
        int c0, dcyc;
        wait_count(92);
        do_grant(c0, dcyc);
        checks++;
        if (dcyc !== c0 + 1 + T_RP + T_RFC) begin
            errors++;
            $display("FAIL early_done_cycle: got %0d, required %0d", dcyc, c0 + 1 + T_RP + T_RFC);
        end
        checks++;
        if (bus.ref_pending !== 4'd0) begin
            errors++;
            $display("FAIL early_credit_pending: got %0d, required 0", bus.ref_pending);
        end
        wait_count(89);
        checks++;
        if (bus.refresh_almost !== 1'b0) begin
            errors++;
            $display("FAIL early_almost_89: got %b, required 0", bus.refresh_almost);
        end
        step(1);
        checks++;
        if (bus.refresh_almost !== 1'b1) begin
            errors++;
            $display("FAIL early_almost_90: got %b, required 1", bus.refresh_almost);
        end
    endtask

    task automatic test_saturate;
        int c0, dcyc;
        for (int i = 1; i <= 9; i++) begin
            wait_count(0);
            checks++;
            if (bus.ref_pending !== 4'(i > 8 ? 8 : i) || bus.ref_overflow !== (i > 8)) begin
                errors++;
                $display("FAIL saturate_tick%0d: got pending %0d overflow %b, required %0d %b",
                         i, bus.ref_pending, bus.ref_overflow, i > 8 ? 8 : i, i > 8);
            end
            step(1);
        end
        do_grant(c0, dcyc);
        checks++;
        if (bus.ref_pending !== 4'd7 || bus.ref_overflow !== 1'b1 || dcyc !== c0 + 1 + T_RP + T_RFC) begin
            errors++;
            $display("FAIL saturate_service: got pending %0d overflow %b done %0d, required 7 1 %0d",
                     bus.ref_pending, bus.ref_overflow, dcyc, c0 + 1 + T_RP + T_RFC);
        end
    endtask

    task automatic test_clear_block;
        int c0, dcyc;
        bus.ref_go = 1'b1;
        bus.clear_refresh = 1'b1;
        step(3);
        checks++;
        if (exp_q.size() !== 0 || bus.refresh_almost !== 1'b1) begin
            errors++;
            $display("FAIL clear_block: got queue %0d almost %b, required 0 1", exp_q.size(), bus.refresh_almost);
        end
        do_grant(c0, dcyc);
        checks++;
        if (dcyc !== c0 + 1 + T_RP + T_RFC || bus.ref_pending !== 4'd6) begin
            errors++;
            $display("FAIL clear_release: got done %0d pending %0d, required %0d 6",
                     dcyc, bus.ref_pending, c0 + 1 + T_RP + T_RFC);
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        c0 = cyc;
        bus.ref_go = 1'b1;
        exp_q.push_back('{REF_PREA, c0 + 1});
        exp_q.push_back('{REF_REF, c0 + 1 + T_RP});
        step(T_RP + 3);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.refresh_almost, bus.refresh_done, bus.ref_cmd_valid, bus.ref_cmd, bus.ref_pending, bus.ref_overflow} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset: got %b, required all zero",
                     {bus.refresh_almost, bus.refresh_done, bus.ref_cmd_valid, bus.ref_cmd, bus.ref_pending, bus.ref_overflow});
        end
        @(negedge clk);
        reset_n = 1'b1;
        step(60);
        checks++;
        if (bus.refresh_done !== 1'b0 || bus.ref_pending !== 4'd0 || bus.refresh_almost !== 1'b0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL post_reset: got done %b pending %0d almost %b queue %0d, required 0 0 0 0",
                     bus.refresh_done, bus.ref_pending, bus.refresh_almost, exp_q.size());
        end
        bus.ref_go = 1'b0;
    endtask

    initial begin
        test_reset;
        test_idle;
        test_service;
        test_early;
        test_saturate;
        test_clear_block;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
